// File: rtl/vector_pkg.sv
// Shared constants for the vector lane ALU: lane geometry, opcodes
// and FSM state encodings.
package vector_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        VADD = 2'b00,
        VSUB = 2'b01,
        VMAX = 2'b10,
        VMIN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

endpackage

// File: rtl/vector_lane_op.sv
// Single-lane combinational datapath: add/sub with carry/borrow flag,
// unsigned max/min. Ports: a, b, op in; result, flag out.
// Saturation on add/sub enabled by VECTOR_LANE_ALU_SATURATE_EN.
module vector_lane_op #(
    parameter int LANE_W = vector_pkg::LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [1:0]        op,
    output logic [LANE_W-1:0] result,
    output logic              flag
);
    import vector_pkg::*;

    logic [LANE_W:0] w_sum;
    logic [LANE_W:0] w_diff;

    // Extra MSB holds carry-out (add) or borrow (sub).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        flag   = 1'b0;
        unique case (op_e'(op))
            VADD: begin
                flag = w_sum[LANE_W];
`ifdef VECTOR_LANE_ALU_SATURATE_EN
                result = w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0];
`else
                result = w_sum[LANE_W-1:0];
`endif
            end
            VSUB: begin
                flag = w_diff[LANE_W];
`ifdef VECTOR_LANE_ALU_SATURATE_EN
                result = w_diff[LANE_W] ? '0 : w_diff[LANE_W-1:0];
`else
                result = w_diff[LANE_W-1:0];
`endif
            end
            VMAX: result = (a > b) ? a : b;
            VMIN: result = (a < b) ? a : b;
            default: ;
        endcase
    end

endmodule

// File: rtl/vector_lane_alu.sv
// Lane-serial vector ALU: captures two source vectors on start, runs one
// lane per EXEC cycle through vector_lane_op, then issues one VRF write.
// Ports: clock, reset_n (async low), start, op, vdata1, vdata2, dest in;
// busy, VRFWrite, vregw, vdataw, vflags out.
// Optional macro: VECTOR_LANE_ALU_SATURATE_EN (saturating add/sub).
module vector_lane_alu #(
    parameter int LANE_W = vector_pkg::LANE_W,
    parameter int LANES  = vector_pkg::LANES
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [LANE_W*LANES-1:0] vdata1,
    input  logic [LANE_W*LANES-1:0] vdata2,
    input  logic [1:0]              dest,
    output logic                    busy,
    output logic                    VRFWrite,
    output logic [1:0]              vregw,
    output logic [LANE_W*LANES-1:0] vdataw,
    output logic [LANES-1:0]        vflags
);
    import vector_pkg::*;

    localparam int VW = LANE_W * LANES;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [1:0]        r_dest;
    logic [VW-1:0]     r_v1;
    logic [VW-1:0]     r_v2;
    logic [VW-1:0]     r_result;
    logic [LANES-1:0]  r_flags;
    logic              r_wr;

    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W-1:0] w_res;
    logic              w_flag;
    logic              w_last;

    // Lane multiplexer feeding the shared lane datapath.
    assign w_a    = r_v1[r_cnt*LANE_W +: LANE_W];
    assign w_b    = r_v2[r_cnt*LANE_W +: LANE_W];
    assign w_last = (r_cnt == CNT_W'(LANES - 1));

    vector_lane_op #(
        .LANE_W (LANE_W)
    ) u_lane (
        .a      (w_a),
        .b      (w_b),
        .op     (r_op),
        .result (w_res),
        .flag   (w_flag)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_dest   <= '0;
            r_v1     <= '0;
            r_v2     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_dest  <= dest;
                        r_v1    <= vdata1;
                        r_v2    <= vdata2;
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result[r_cnt*LANE_W +: LANE_W] <= w_res;
                    r_flags[r_cnt] <= w_flag;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= WB;
                        r_wr    <= 1'b1;
                    end
                end
                WB: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign VRFWrite = r_wr;
    assign vregw    = r_dest;
    assign vdataw   = r_result;
    assign vflags   = r_flags;

endmodule
